mac_operand_sequencer: RTL and testbench

Drives the MAC unit from the host side of its start/finish handshake. Host software queues 8-bit operand pairs into a small FIFO, then issues `go`. The block clears the accumulator, feeds each pair to the MAC with a one-cycle start pulse and waits for its finish, then captures the 20-bit accumulated result. It sits between the host register interface and the MAC instance, and includes a watchdog against a hung MAC.

---
 rtl/mac_operand_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_operand_sequencer
// Purpose  : Queues 8-bit operand pairs and feeds them to a MAC over a
//            start/finish handshake, with a per-pair watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mac_operand_sequencer #(
  parameter int DEPTH   = 8,
  parameter int ACC_W   = 20,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [7:0]               i_wr_a,
  input  logic [7:0]               i_wr_b,
  input  logic                     i_go,
  input  logic                     i_mac_finish,
  input  logic [ACC_W-1:0]         i_mac_rc,
  output logic                     o_mac_clear,
  output logic                     o_mac_start,
  output logic [7:0]               o_mac_op_a,
  output logic [7:0]               o_mac_op_b,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ACC_W-1:0]         o_result,
  output logic                     o_overflow,
  output logic                     o_timeout_err
);
  localparam int c_AW  = $clog2(DEPTH);
  localparam int c_WDW = $clog2(TIMEOUT);
  localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TIMEOUT - 1);
  localparam logic [c_AW:0]    c_ONE     = (c_AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr, w_head_ptr;
  logic [c_AW:0]     r_count, w_count_nxt;
  logic              r_full;
  logic [c_WDW-1:0]  r_wd;
  logic [7:0]        r_op_a, r_op_b;
  logic              r_mac_clear, r_mac_start, r_busy, r_done;
  logic              r_overflow, r_timeout_err;
  logic [ACC_W-1:0]  r_result;
  logic              w_push_ok, w_push, w_pop, w_flush, w_go_accept, w_timeout, w_more;
  logic [15:0]       w_head;

  assign w_push_ok = i_wr_en && !r_full;
  // After popping the current pair, work remains if older pairs are queued or one arrives now.
  assign w_more    = (r_count > c_ONE) || w_push_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_go_accept = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_go && (r_count != '0)) begin
          w_go_accept = 1'b1;
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR:   w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_mac_finish) begin
          w_pop       = 1'b1;
          w_state_nxt = w_more ? S_ISSUE : S_CAPTURE;
        end else if (r_wd == c_WD_LAST) begin
          w_timeout   = 1'b1;
          w_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_CAPTURE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign w_push = w_push_ok && !w_flush;

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush)              w_count_nxt = '0;
    else if (w_push && !w_pop) w_count_nxt = r_count + c_ONE;
    else if (w_pop && !w_push) w_count_nxt = r_count - c_ONE;
  end

  // A pair written in the same cycle the last queued pair pops is not in memory yet.
  assign w_head_ptr = w_pop ? (r_rd_ptr + c_AW'(1)) : r_rd_ptr;
  assign w_head     = (w_pop && (r_count == c_ONE)) ? {i_wr_a, i_wr_b} : r_mem[w_head_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_wr_a, i_wr_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_wd          <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_mac_clear   <= 1'b0;
      r_mac_start   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_flush)    r_rd_ptr <= r_wr_ptr;
      else if (w_pop) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (c_AW+1)'(DEPTH));

      if (w_state_nxt == S_ISSUE) begin
        r_wd   <= '0;
        r_op_a <= w_head[15:8];
        r_op_b <= w_head[7:0];
      end else if (r_state == S_ISSUE || r_state == S_WAIT) begin
        r_wd <= r_wd + c_WDW'(1);
      end

      r_mac_clear <= (w_state_nxt == S_CLEAR);
      r_mac_start <= (w_state_nxt == S_ISSUE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_CAPTURE);
      if (w_state_nxt == S_CAPTURE) r_result <= i_mac_rc;

      if (w_go_accept)          r_overflow <= 1'b0;
      if (i_wr_en && r_full)    r_overflow <= 1'b1;
      if (w_go_accept)          r_timeout_err <= 1'b0;
      if (w_timeout)            r_timeout_err <= 1'b1;
    end
  end

  assign o_mac_clear   = r_mac_clear;
  assign o_mac_start   = r_mac_start;
  assign o_mac_op_a    = r_op_a;
  assign o_mac_op_b    = r_op_b;
  assign o_full        = r_full;
  assign o_count       = r_count;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_result      = r_result;
  assign o_overflow    = r_overflow;
  assign o_timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_operand_sequencer
// Purpose  : Directed bench with a MAC model and an event scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_operand_sequencer;
  localparam int DEPTH   = 8;
  localparam int ACC_W   = 20;
  localparam int TIMEOUT = 64;
  localparam int K_CLR   = 0;
  localparam int K_START = 1;
  localparam int K_DONE  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_a = '0, wr_b = '0;
  logic             go = 1'b0;
  logic             mac_finish;
  logic [ACC_W-1:0] mac_rc;
  logic             mac_clear, mac_start, full, busy, done, overflow, timeout_err;
  logic [7:0]       op_a, op_b;
  logic [3:0]       count;
  logic [ACC_W-1:0] result;

  mac_operand_sequencer #(.DEPTH(DEPTH), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_a(wr_a), .i_wr_b(wr_b), .i_go(go),
    .i_mac_finish(mac_finish), .i_mac_rc(mac_rc),
    .o_mac_clear(mac_clear), .o_mac_start(mac_start), .o_mac_op_a(op_a), .o_mac_op_b(op_b),
    .o_full(full), .o_count(count), .o_busy(busy), .o_done(done), .o_result(result),
    .o_overflow(overflow), .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // MAC model: accumulates on start, raises finish k_lat cycles later unless hung.
  int   k_lat = 3;
  bit   hang  = 1'b0;
  int   cd    = 0;
  logic [ACC_W-1:0] acc;
  assign mac_rc = acc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0; mac_finish <= 1'b0; cd <= 0;
    end else begin
      mac_finish <= 1'b0;
      if (cd > 0) begin
        cd <= cd - 1;
        if (cd == 1 && !hang) mac_finish <= 1'b1;
      end
      if (mac_clear) acc <= '0;
      if (mac_start) begin
        acc        <= acc + ({12'd0, op_a} * {12'd0, op_b});
        cd         <= k_lat - 1;
        mac_finish <= (k_lat == 1) && !hang;
      end
    end
  end

  typedef struct { int kind; logic [31:0] val; } exp_t;
  exp_t sb[$];

  task automatic expect_ev(input int kind, input logic [31:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string name, input int kind, input logic [31:0] val);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event kind %0d value 0x%0h, nothing expected", name, kind, val);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val !== val) begin
        n_fail++;
        $display("FAIL %s: got kind %0d value 0x%0h, expected kind %0d value 0x%0h",
                 name, kind, val, e.kind, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mac_clear) sb_check("sb_clear", K_CLR, 32'd0);
      if (mac_start) sb_check("sb_start", K_START, {16'd0, op_a, op_b});
      if (done)      sb_check("sb_done", K_DONE, {12'd0, result});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    wr_en = 1'b1; wr_a = a; wr_b = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_go(output int t);
    go = 1'b1;
    t  = cyc;
    step();
    go = 1'b0;
  endtask

  task automatic wait_done(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
    end
    step();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ctl"}, {mac_clear, mac_start, full, busy, done, overflow, timeout_err}, 64'd0);
    chk({name, "_data"}, {op_a, op_b, count, result}, 64'd0);
  endtask

  initial begin
    int t, at;
    bit seen_busy;

    // Reset state
    #2;
    chk_reset_outputs("reset");
    step();
    rst = 1'b0;
    step();

    // Three pairs, k=3
    k_lat = 3;
    push(8'd3, 8'd4); push(8'd5, 8'd6); push(8'd255, 8'd255);
    chk("t1_count", count, 3);
    expect_ev(K_CLR, 0);
    expect_ev(K_START, 32'h0304);
    expect_ev(K_START, 32'h0506);
    expect_ev(K_START, 32'hFFFF);
    expect_ev(K_DONE, 32'd65067);
    pulse_go(t);
    chk("t1_busy_clear", {busy, mac_clear}, 2'b11);
    wait_done(100, at);
    chk("t1_done_time", at, t + 14);
    chk("t1_idle", {busy, count}, 0);
    chk("t1_result_held", result, 65067);

    // go with empty FIFO is ignored
    pulse_go(t);
    seen_busy = busy;
    for (int i = 0; i < 4; i++) begin
      step();
      seen_busy |= busy;
    end
    chk("t2_no_busy", seen_busy, 0);

    // Overflow: 9 writes, 8 accepted, k=1
    k_lat = 1;
    for (int i = 1; i <= 8; i++) push(8'(i), 8'(i + 1));
    chk("t3_full_after8", {full, count, overflow}, {1'b1, 4'd8, 1'b0});
    push(8'd9, 8'd10);
    chk("t3_overflow", {full, count, overflow}, {1'b1, 4'd8, 1'b1});
    expect_ev(K_CLR, 0);
    for (int i = 1; i <= 8; i++) expect_ev(K_START, {16'd0, 8'(i), 8'(i + 1)});
    expect_ev(K_DONE, 32'd240);
    pulse_go(t);
    chk("t3_overflow_cleared", overflow, 0);
    wait_done(100, at);
    chk("t3_done_time", at, t + 18);

    // Second pair written in WAIT, on the finish cycle, k=2
    k_lat = 2;
    push(8'd10, 8'd20);
    expect_ev(K_CLR, 0);
    expect_ev(K_START, 32'h0A14);
    expect_ev(K_START, 32'h0708);
    expect_ev(K_DONE, 32'd256);
    pulse_go(t);
    step(); step(); step();
    push(8'd7, 8'd8);
    wait_done(100, at);
    chk("t4_done_time", at, t + 8);

    // Hung MAC: watchdog
    hang = 1'b1;
    push(8'd1, 8'd1); push(8'd2, 8'd2);
    expect_ev(K_CLR, 0);
    expect_ev(K_START, 32'h0101);
    pulse_go(t);
    while (cyc < t + 2 + TIMEOUT - 1) step();
    chk("t5_before_timeout", {timeout_err, busy, count}, {1'b0, 1'b1, 4'd2});
    step();
    chk("t5_timeout", {timeout_err, busy, count, full}, {1'b1, 1'b0, 4'd0, 1'b0});
    for (int i = 0; i < 5; i++) step();
    chk("t5_sticky", timeout_err, 1);
    hang = 1'b0;

    // Reset during WAIT
    k_lat = 3;
    push(8'd2, 8'd3); push(8'd4, 8'd5); push(8'd6, 8'd7);
    expect_ev(K_CLR, 0);
    expect_ev(K_START, 32'h0203);
    pulse_go(t);
    step(); step();
    chk("t6_in_wait", {busy, timeout_err, count, op_a, op_b}, {1'b1, 1'b0, 4'd3, 8'd2, 8'd3});
    #3 rst = 1'b1;
    #1 chk_reset_outputs("t6_async_reset");
    step();
    rst = 1'b0;
    step();
    pulse_go(t);
    seen_busy = busy;
    for (int i = 0; i < 4; i++) begin
      step();
      seen_busy |= busy;
    end
    chk("t6_go_ignored", {seen_busy, count}, 0);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench time limit expired");
  end

endmodule
`default_nettype wire
